hash_code_checker: RTL
======================

HASH_CODE_CHECKER -- requirements
Module: hash_code_checker

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 5, number of BCD digits per entry (MSD first).
REQ-002 SHALL have parameter MAX_FAILS, default 3, consecutive mismatches that trigger lockout.
REQ-003 SHALL have parameter LOCK_CYCLES, default 2500, lockout length in clk cycles (5 s at 500 Hz).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 digit_in  input  4  BCD digit from user entry.
REQ-007 digit_valid  input  1  digit_in sampled on this clk edge when high.
REQ-008 clear  input  1  abort current entry.
REQ-009 expected_hash  input  16  current hash value, compared at end of entry.
REQ-010 digit_count  output  3  digits accepted so far in current entry.
REQ-011 entered_value  output  16  low 16 bits of the binary accumulator.
REQ-012 result_valid  output  1  one-cycle strobe, entry complete.
REQ-013 match  output  1  valid with result_valid; entry equals expected_hash.
REQ-014 overflow  output  1  valid with result_valid; entered number > 65535.
REQ-015 bad_digit  output  1  one-cycle strobe, non-BCD digit rejected.
REQ-016 locked  output  1  high while in lockout.

Function
REQ-017 SHALL implement FSM states IDLE, COLLECT, CHECK, LOCKED; all outputs registered or decoded from registers.
REQ-018 SHALL hold a 17-bit accumulator acc; each accepted digit updates acc = acc*10 + digit_in (first digit: acc = digit_in); digit_count increments.
REQ-019 IDLE/COLLECT, digit_valid with digit_in<=9: accept; on the edge accepting digit NUM_DIGITS, go to CHECK.
REQ-020 IDLE/COLLECT, digit_valid with digit_in>9: acc=0, digit_count=0, state IDLE, bad_digit=1 for next cycle only; fail counter unchanged.
REQ-021 CHECK lasts exactly one cycle; during it result_valid=1, overflow=acc[16], match=(acc[16]==0 && acc[15:0]==expected_hash sampled on the entry edge into CHECK).
REQ-022 CHECK exit with match=1: fail counter=0, acc=0, digit_count=0, go IDLE.
REQ-023 CHECK exit with match=0: fail counter+1; if it reaches MAX_FAILS, go LOCKED with timer=LOCK_CYCLES-1 and fail counter=0, else IDLE; acc, digit_count cleared.
REQ-024 LOCKED: locked=1, digit_valid and clear ignored, timer decrements each cycle; on timer==0 edge go IDLE.
REQ-025 clear in IDLE/COLLECT: acc=0, digit_count=0, state IDLE, fail counter unchanged; clear wins over simultaneous digit_valid.
REQ-026 digit_valid and clear ignored in CHECK.
REQ-027 match, overflow SHALL be 0 whenever result_valid=0.
REQ-028 expected_hash changing mid-entry SHALL not affect result; only value at the CHECK-entry edge counts.

Reset
REQ-029 rst high SHALL immediately force IDLE, acc=0, digit_count=0, fail counter=0, timer=0, all strobes 0, locked=0, including mid-entry and mid-lockout.
REQ-030 After rst deasserts, first digit_valid edge SHALL be accepted normally.

Verification
REQ-031 expected_hash=0x3039, digits 1,2,3,4,5 -> result_valid one cycle after 5th digit edge, match=1, overflow=0, entered_value=0x3039.
REQ-032 expected_hash=0x0000, digits 6,5,5,3,6 -> result_valid=1, overflow=1, match=0, entered_value=0x0000.
REQ-033 Three mismatched entries -> locked=1 after 3rd CHECK for exactly 2500 cycles; digits during lockout ignored (digit_count stays 0); then correct entry gives match=1.
REQ-034 Digits 4,2 then 0xA -> bad_digit one cycle, digit_count=0, no result_valid; subsequent 1,2,3,4,5 matches 0x3039.
REQ-035 clear and digit_valid(7) same edge after two digits -> digit_count=0, acc=0; rst asserted after 3 digits -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hash_code_checker.sv
// hash_code_checker
// Collects a fixed-length BCD code entry (MSD first) and converts it into a binary
// value. When the last digit arrives, the value is compared against the hash
// sampled on that same edge. A number of consecutive mismatches triggers a timed
// lockout, during which all entry input is ignored.
//
// Ports
//   clk            single clock; all state updates on the rising edge
//   rst            asynchronous active-high reset
//   digit_in       BCD digit from user entry
//   digit_valid    digit_in is sampled on this edge when high
//   clear          abort the current entry (wins over digit_valid)
//   expected_hash  reference value, sampled on the edge that completes an entry
//   digit_count    digits accepted so far in the current entry
//   entered_value  low 16 bits of the binary accumulator
//   result_valid   one-cycle strobe: the entry is complete
//   match          qualified by result_valid: the entry equals the sampled hash
//   overflow       qualified by result_valid: the entered number exceeds 65535
//   bad_digit      one-cycle strobe: a non-BCD digit was rejected
//   locked         high while in lockout
module hash_code_checker #(
  parameter int NUM_DIGITS  = 5,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_in,
  input  logic        digit_valid,
  input  logic        clear,
  input  logic [15:0] expected_hash,
  output logic [2:0]  digit_count,
  output logic [15:0] entered_value,
  output logic        result_valid,
  output logic        match,
  output logic        overflow,
  output logic        bad_digit,
  output logic        locked
);

  localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int FW = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [16:0]     acc_q, acc_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [FW-1:0]   fails_q, fails_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     hash_q, hash_d;
  logic            bad_q, bad_d;

  logic [16:0]     acc_digit;
  logic [2:0]      cnt_inc;
  logic [FW-1:0]   fails_inc;
  logic            hit;

  // acc is zero at the start of every entry, so acc*10+digit also covers the
  // first-digit case (acc = digit_in).
  assign acc_digit = (acc_q * 17'd10) + {13'd0, digit_in};
  assign cnt_inc   = cnt_q + 3'd1;
  assign fails_inc = fails_q + {{(FW-1){1'b0}}, 1'b1};
  assign hit       = !acc_q[16] && (acc_q[15:0] == hash_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      fails_q <= '0;
      timer_q <= '0;
      hash_q  <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      fails_q <= fails_d;
      timer_q <= timer_d;
      hash_q  <= hash_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    fails_d = fails_q;
    timer_d = timer_q;
    hash_d  = hash_q;
    bad_d   = 1'b0;

    case (state_q)
      IDLE, COLLECT: begin
        if (clear) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (digit_valid) begin
          if (digit_in > 4'd9) begin
            acc_d   = '0;
            cnt_d   = '0;
            bad_d   = 1'b1;
            state_d = IDLE;
          end else begin
            acc_d = acc_digit;
            cnt_d = cnt_inc;
            if (cnt_inc == 3'(NUM_DIGITS)) begin
              hash_d  = expected_hash;
              state_d = CHECK;
            end else begin
              state_d = COLLECT;
            end
          end
        end
      end

      CHECK: begin
        acc_d = '0;
        cnt_d = '0;
        if (hit) begin
          fails_d = '0;
          state_d = IDLE;
        end else if (fails_inc == FW'(MAX_FAILS)) begin
          fails_d = '0;
          timer_d = TW'(LOCK_CYCLES - 1);
          state_d = LOCKED;
        end else begin
          fails_d = fails_inc;
          state_d = IDLE;
        end
      end

      LOCKED: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - {{(TW-1){1'b0}}, 1'b1};
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign digit_count   = cnt_q;
  assign entered_value = acc_q[15:0];
  assign result_valid  = (state_q == CHECK);
  assign match         = result_valid && hit;
  assign overflow      = result_valid && acc_q[16];
  assign bad_digit     = bad_q;
  assign locked        = (state_q == LOCKED);

endmodule
